pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage riscv_processor pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the riscv_processor pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect and data-memory wait
// hazards, with saturating statistics and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW   = pipeline_ctrl_pkg::REG_AW,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              hold_all,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic              mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              memw;
  logic              lu;
  logic              rd;
  logic [WAIT_W-1:0] wait_cnt;
  hz_state_t         state_q;

  assign memw = mem_req & ~mem_ready;
  assign rd   = ex_valid & ex_redirect;
  assign lu   = ex_valid & ex_mem_read & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Enables are combinational so the pipe reacts in the same cycle the hazard appears.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    hold_all = 1'b0;
    if (!rst) begin
      if (memw) begin
        hold_all = 1'b1;
        stall    = 1'b1;
      end else if (rd) begin
        flush = 1'b1;
      end else if (lu) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // Hazard terms are re-evaluated every cycle, so the state only records which one won.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else if (memw) begin
      state_q <= MEM_WAIT;
    end else if (rd) begin
      state_q <= REDIRECT;
    end else if (lu) begin
      state_q <= LOAD_USE;
    end else begin
      state_q <= RUN;
    end
  end

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
      mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .clr (1'b0),
    .q   (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (1'b0),
    .q   (flush_count)
  );

  // The wait counter restarts whenever the memory is not stalling the pipe.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (memw),
    .clr (~memw),
    .q   (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; counters narrowed to 4 bits to reach saturation.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;
  localparam int MAX_WAIT = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_valid, ex_mem_read, ex_redirect;
  logic             mem_req, mem_ready;
  logic             stall, bubble, flush, hold_all, mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int vectors     = 0;
  int miscompares = 0;
  int exp_stall   = 0;
  int exp_flush   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_AW   (5),
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .bubble      (bubble),
    .flush       (flush),
    .hold_all    (hold_all),
    .state       (state),
    .stall_count (stall_count),
    .flush_count (flush_count),
    .mem_timeout (mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_enables(input string tag, input logic s, input logic b, input logic f, input logic h);
    #2;
    check({tag, ".stall"},    {31'd0, stall},    {31'd0, s});
    check({tag, ".bubble"},   {31'd0, bubble},   {31'd0, b});
    check({tag, ".flush"},    {31'd0, flush},    {31'd0, f});
    check({tag, ".hold_all"}, {31'd0, hold_all}, {31'd0, h});
  endtask

  task automatic check_regs(input string tag, input logic [1:0] st);
    check({tag, ".state"},       {30'd0, state},    {30'd0, st});
    check({tag, ".stall_count"}, 32'(stall_count),  32'(exp_stall));
    check({tag, ".flush_count"}, 32'(flush_count),  32'(exp_flush));
  endtask

  task automatic load_use_on();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd1; id_rs2 = 5'd3; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step(); step();
    check_enables("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_regs("reset", 2'd0);
    check("reset.mem_timeout", {31'd0, mem_timeout}, 32'd0);

    // T1: lw x3 in EX, add x4,x1,x3 in ID.
    rst = 1'b0;
    step();
    load_use_on();
    check_enables("t1_lu", 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    exp_stall = sat_inc(exp_stall);
    check_regs("t1_after", 2'd1);
    idle();
    check_enables("t1_bubble_in_ex", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("t1_run", 2'd0);

    // T2: x0 destination never hazards; invalid EX never hazards; unused operand never hazards.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    check_enables("t2_x0", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5;
    check_enables("t2_invalid", 1'b0, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b1; id_use_rs1 = 1'b0;
    check_enables("t2_unused", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("t2_run", 2'd0);

    // T3: taken branch resolved in EX.
    idle();
    ex_valid = 1'b1; ex_redirect = 1'b1;
    check_enables("t3_rd", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp_flush = sat_inc(exp_flush);
    check_regs("t3_after", 2'd2);
    idle();
    check_enables("t3_gone", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_regs("t3_run", 2'd0);

    // T4: redirect held in a frozen EX during a 3-cycle memory wait.
    ex_valid = 1'b1; ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_enables($sformatf("t4_wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      exp_stall = sat_inc(exp_stall);
      check_regs($sformatf("t4_wait%0d", i), 2'd3);
    end
    mem_ready = 1'b1;
    check_enables("t4_ready", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp_flush = sat_inc(exp_flush);
    check_regs("t4_after", 2'd2);

    // T5: load-use and redirect together -> flush only; then a 16-cycle memory wait.
    idle();
    load_use_on();
    ex_redirect = 1'b1;
    check_enables("t5_lu_rd", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp_flush = sat_inc(exp_flush);
    check_regs("t5_lu_rd", 2'd2);
    idle();
    mem_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_stall = sat_inc(exp_stall);
      check($sformatf("t5_timeout%0d", i), {31'd0, mem_timeout}, (i >= 16) ? 32'd1 : 32'd0);
    end
    check_regs("t5_wait_end", 2'd3);
    mem_ready = 1'b1;
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    step(); step();
    check("t5_sticky", {31'd0, mem_timeout}, 32'd1);
    check_regs("t5_release", 2'd0);

    // T6: reset in MEM_WAIT with hazards present, then stall-counter saturation.
    mem_req = 1'b1;
    step();
    check_regs("t6_memwait", 2'd3);
    rst = 1'b1;
    load_use_on();
    ex_redirect = 1'b1;
    check_enables("t6_rst_same_cycle", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_stall = 0;
    exp_flush = 0;
    check_regs("t6_rst", 2'd0);
    check("t6_rst.mem_timeout", {31'd0, mem_timeout}, 32'd0);
    idle();
    rst = 1'b0;
    load_use_on();
    for (int i = 0; i < 20; i++) begin
      step();
      exp_stall = sat_inc(exp_stall);
    end
    check_regs("t6_saturate", 2'd1);
    check("t6_saturate.value", 32'(stall_count), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
